// File: rtl/map_sub.sv
// map_sub: three-stage signed-magnitude adder forming A + BIAS for the pre-map path.
// Stages: S1 align, S2 add/subtract, S3 normalize; sideband travels with each beat.
module map_sub #(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 32,
  parameter int unsigned GUARD      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sign_a,
  input  logic [EXP_WIDTH-1:0]  i_exp_a,
  input  logic [FRAC_WIDTH-1:0] i_frac_a,
  input  logic                  i_sign_bias,
  input  logic [EXP_WIDTH-1:0]  i_exp_bias,
  input  logic [FRAC_WIDTH-1:0] i_frac_bias,
  input  logic                  i_sincos_proced,
  input  logic                  i_RESULT_SIGN_FLIP,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sign_r,
  output logic [EXP_WIDTH-1:0]  o_exp_r,
  output logic [FRAC_WIDTH-1:0] o_frac_r,
  output logic                  o_sincos_proced,
  output logic                  o_RESULT_SIGN_FLIP
);

  localparam int unsigned AW  = FRAC_WIDTH + GUARD;
  localparam int unsigned SW  = AW + 1;
  localparam int unsigned LZW = $clog2(AW + 1);

  function automatic logic [LZW-1:0] lzc(input logic [AW-1:0] v);
    logic found;
    lzc   = {LZW{1'b0}};
    found = 1'b0;
    for (int i = AW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        found = 1'b1;
        lzc   = LZW'(AW - 1 - i);
      end
    end
  endfunction

  logic en1_s, en2_s, en3_s;
  logic v1_r, v2_r;

  logic                  s1_sign_r, s1_sub_r, s1_sc_r, s1_flip_r;
  logic [EXP_WIDTH-1:0]  s1_exp_r;
  logic [AW-1:0]         s1_big_r, s1_small_r;

  logic                  s2_sign_r, s2_sc_r, s2_flip_r;
  logic [EXP_WIDTH-1:0]  s2_exp_r;
  logic [SW-1:0]         s2_sum_r;

  logic                  a_zero_s, b_zero_s, a_big_s, small_zero_s;
  logic                  sign_big_s;
  logic [EXP_WIDTH-1:0]  exp_big_s, exp_small_s, d_s;
  logic [FRAC_WIDTH-1:0] frac_big_s, frac_small_s;
  logic [AW-1:0]         small_al_s;
  logic [SW-1:0]         sum_s;
  logic [LZW-1:0]        lz_s;
  logic [AW-1:0]         norm_sh_s;
  logic                  n_sign_s;
  logic [EXP_WIDTH-1:0]  n_exp_s;
  logic [FRAC_WIDTH-1:0] n_frac_s;

  // A stage may load when its successor is empty or draining this cycle.
  assign en3_s   = ~o_valid | i_ready;
  assign en2_s   = ~v2_r | en3_s;
  assign en1_s   = ~v1_r | en2_s;
  assign o_ready = en1_s;

  // Operand ordering and alignment; a zero fraction never wins the magnitude compare.
  always_comb begin
    a_zero_s     = (i_frac_a == {FRAC_WIDTH{1'b0}});
    b_zero_s     = (i_frac_bias == {FRAC_WIDTH{1'b0}});
    a_big_s      = b_zero_s | (~a_zero_s & ({i_exp_a, i_frac_a} >= {i_exp_bias, i_frac_bias}));
    sign_big_s   = i_sign_a;
    exp_big_s    = i_exp_a;
    frac_big_s   = i_frac_a;
    exp_small_s  = i_exp_bias;
    frac_small_s = i_frac_bias;
    small_zero_s = b_zero_s;
    if (a_big_s) begin
      sign_big_s   = i_sign_a;
      exp_big_s    = i_exp_a;
      frac_big_s   = i_frac_a;
      exp_small_s  = i_exp_bias;
      frac_small_s = i_frac_bias;
      small_zero_s = b_zero_s;
    end else begin
      sign_big_s   = i_sign_bias;
      exp_big_s    = i_exp_bias;
      frac_big_s   = i_frac_bias;
      exp_small_s  = i_exp_a;
      frac_small_s = i_frac_a;
      small_zero_s = a_zero_s;
    end
    d_s = exp_big_s - exp_small_s;
    if (small_zero_s || (32'(d_s) >= AW)) begin
      small_al_s = {AW{1'b0}};
    end else begin
      small_al_s = {frac_small_s, {GUARD{1'b0}}} >> d_s;
    end
  end

  // Magnitude add or subtract; BIG >= small so the difference never goes negative.
  always_comb begin
    if (s1_sub_r) begin
      sum_s = {1'b0, s1_big_r} - {1'b0, s1_small_r};
    end else begin
      sum_s = {1'b0, s1_big_r} + {1'b0, s1_small_r};
    end
  end

  // Normalization: carry shifts right (saturating at max exponent), otherwise shift out leading zeros.
  always_comb begin
    lz_s      = lzc(s2_sum_r[AW-1:0]);
    norm_sh_s = s2_sum_r[AW-1:0] << lz_s;
    n_sign_s  = 1'b0;
    n_exp_s   = {EXP_WIDTH{1'b0}};
    n_frac_s  = {FRAC_WIDTH{1'b0}};
    if (s2_sum_r[SW-1]) begin
      n_sign_s = s2_sign_r;
      if (&s2_exp_r) begin
        n_exp_s  = {EXP_WIDTH{1'b1}};
        n_frac_s = {FRAC_WIDTH{1'b1}};
      end else begin
        n_exp_s  = s2_exp_r + {{(EXP_WIDTH-1){1'b0}}, 1'b1};
        n_frac_s = s2_sum_r[SW-1 -: FRAC_WIDTH];
      end
    end else if (s2_sum_r == {SW{1'b0}}) begin
      n_sign_s = 1'b0;
    end else if (32'(lz_s) > 32'(s2_exp_r)) begin
      n_sign_s = 1'b0;
    end else begin
      n_sign_s = s2_sign_r;
      n_exp_s  = s2_exp_r - EXP_WIDTH'(lz_s);
      n_frac_s = norm_sh_s[AW-1 -: FRAC_WIDTH];
    end
  end

  // Stage occupancy; reset discards every in-flight beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      if (en1_s) v1_r    <= i_valid;
      if (en2_s) v2_r    <= v1_r;
      if (en3_s) o_valid <= v2_r;
    end
  end

  // S1 align register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_sign_r  <= 1'b0;
      s1_sub_r   <= 1'b0;
      s1_exp_r   <= {EXP_WIDTH{1'b0}};
      s1_big_r   <= {AW{1'b0}};
      s1_small_r <= {AW{1'b0}};
      s1_sc_r    <= 1'b0;
      s1_flip_r  <= 1'b0;
    end else if (en1_s && i_valid) begin
      s1_sign_r  <= sign_big_s;
      s1_sub_r   <= i_sign_a ^ i_sign_bias;
      s1_exp_r   <= exp_big_s;
      s1_big_r   <= {frac_big_s, {GUARD{1'b0}}};
      s1_small_r <= small_al_s;
      s1_sc_r    <= i_sincos_proced;
      s1_flip_r  <= i_RESULT_SIGN_FLIP;
    end
  end

  // S2 add register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_sign_r <= 1'b0;
      s2_exp_r  <= {EXP_WIDTH{1'b0}};
      s2_sum_r  <= {SW{1'b0}};
      s2_sc_r   <= 1'b0;
      s2_flip_r <= 1'b0;
    end else if (en2_s && v1_r) begin
      s2_sign_r <= s1_sign_r;
      s2_exp_r  <= s1_exp_r;
      s2_sum_r  <= sum_s;
      s2_sc_r   <= s1_sc_r;
      s2_flip_r <= s1_flip_r;
    end
  end

  // S3 output register; holds while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sign_r           <= 1'b0;
      o_exp_r            <= {EXP_WIDTH{1'b0}};
      o_frac_r           <= {FRAC_WIDTH{1'b0}};
      o_sincos_proced    <= 1'b0;
      o_RESULT_SIGN_FLIP <= 1'b0;
    end else if (en3_s && v2_r) begin
      o_sign_r           <= n_sign_s;
      o_exp_r            <= n_exp_s;
      o_frac_r           <= n_frac_s;
      o_sincos_proced    <= s2_sc_r;
      o_RESULT_SIGN_FLIP <= s2_flip_r;
    end
  end

endmodule

// File: tb/tb_map_sub.sv
// Bench for map_sub: directed cases plus randomized traffic with random back-pressure,
// scored against an arithmetic reference model through an in-order expectation queue.
module tb_map_sub;

  typedef struct packed {
    logic        sa;
    logic [7:0]  ea;
    logic [31:0] fa;
    logic        sb;
    logic [7:0]  eb;
    logic [31:0] fb;
    logic        sc;
    logic        fl;
  } in_t;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [31:0] f;
    logic        sc;
    logic        fl;
  } res_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sign_a = 1'b0;
  logic [7:0]  i_exp_a = 8'h00;
  logic [31:0] i_frac_a = 32'h0;
  logic        i_sign_bias = 1'b0;
  logic [7:0]  i_exp_bias = 8'h00;
  logic [31:0] i_frac_bias = 32'h0;
  logic        i_sincos_proced = 1'b0;
  logic        i_RESULT_SIGN_FLIP = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_sign_r;
  logic [7:0]  o_exp_r;
  logic [31:0] o_frac_r;
  logic        o_sincos_proced;
  logic        o_RESULT_SIGN_FLIP;

  map_sub #(.EXP_WIDTH(8), .FRAC_WIDTH(32), .GUARD(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign_a(i_sign_a), .i_exp_a(i_exp_a), .i_frac_a(i_frac_a),
    .i_sign_bias(i_sign_bias), .i_exp_bias(i_exp_bias), .i_frac_bias(i_frac_bias),
    .i_sincos_proced(i_sincos_proced), .i_RESULT_SIGN_FLIP(i_RESULT_SIGN_FLIP),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_sign_r(o_sign_r), .o_exp_r(o_exp_r), .o_frac_r(o_frac_r),
    .o_sincos_proced(o_sincos_proced), .o_RESULT_SIGN_FLIP(o_RESULT_SIGN_FLIP)
  );

  always #5 i_clk = ~i_clk;

  res_t dut_res;
  assign dut_res = {o_sign_r, o_exp_r, o_frac_r, o_sincos_proced, o_RESULT_SIGN_FLIP};

  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;
  res_t exp_q[$];
  logic accepted, popped, hold_chk, saw_not_ready;
  res_t held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: value-level add of two sign/exp/frac operands with GUARD=2 extra bits.
  function automatic res_t model(input in_t b);
    res_t r;
    logic a_big, sbig;
    int eb, es, d, lz;
    longint unsigned fbig, fsml, bx, sx, sum;
    a_big = (b.fb == 32'h0) || ((b.fa != 32'h0) && ({b.ea, b.fa} >= {b.eb, b.fb}));
    if (a_big) begin
      sbig = b.sa; eb = int'(b.ea); fbig = longint'(b.fa); es = int'(b.eb); fsml = longint'(b.fb);
    end else begin
      sbig = b.sb; eb = int'(b.eb); fbig = longint'(b.fb); es = int'(b.ea); fsml = longint'(b.fa);
    end
    bx = fbig * 64'd4;
    d  = eb - es;
    sx = 64'd0;
    if (fsml != 64'd0 && d < 34) sx = (fsml * 64'd4) >> d;
    sum = (b.sa ^ b.sb) ? (bx - sx) : (bx + sx);
    r = '0;
    r.sc = b.sc;
    r.fl = b.fl;
    if (sum == 64'd0) begin
      r.s = 1'b0;
    end else if (sum >= (64'd1 << 34)) begin
      r.s = sbig;
      if (eb == 255) begin
        r.e = 8'hFF; r.f = 32'hFFFF_FFFF;
      end else begin
        r.e = 8'(eb + 1); r.f = 32'(sum >> 3);
      end
    end else begin
      lz = 0;
      while (sum < (64'd1 << 33)) begin
        sum = sum * 64'd2;
        lz++;
      end
      if (lz <= eb) begin
        r.s = sbig; r.e = 8'(eb - lz); r.f = 32'(sum >> 2);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_frac();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h0;
    if (k == 1) return 32'($urandom);
    return {1'b1, 31'($urandom)};
  endfunction

  function automatic in_t rand_in();
    in_t b;
    int e;
    b.sa = 1'($urandom_range(0, 1));
    b.sb = 1'($urandom_range(0, 1));
    b.ea = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    e = int'(b.ea) + $urandom_range(0, 80) - 40;
    if ($urandom_range(0, 7) == 0) e = $urandom_range(0, 255);
    if (e < 0) e = 0;
    if (e > 255) e = 255;
    b.eb = 8'(e);
    b.fa = rand_frac();
    b.fb = ($urandom_range(0, 3) == 0) ? b.fa : rand_frac();
    b.sc = 1'($urandom_range(0, 1));
    b.fl = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // One clock of traffic: drive at the falling edge, score the handshakes that the next rising edge will perform.
  task automatic cycle(input logic v, input logic rdy, input in_t b, input logic use_e, input res_t e);
    @(negedge i_clk);
    i_valid = v; i_ready = rdy;
    i_sign_a = b.sa; i_exp_a = b.ea; i_frac_a = b.fa;
    i_sign_bias = b.sb; i_exp_bias = b.eb; i_frac_bias = b.fb;
    i_sincos_proced = b.sc; i_RESULT_SIGN_FLIP = b.fl;
    #1;
    accepted = 1'b0;
    popped   = 1'b0;
    if (hold_chk) check("hold_stable", 64'(dut_res), 64'(held));
    hold_chk = o_valid && !i_ready;
    held     = dut_res;
    if (!o_ready) saw_not_ready = 1'b1;
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 64'd1, 64'd0);
      end else begin
        check("result", 64'(dut_res), 64'(exp_q.pop_front()));
      end
      popped = 1'b1;
      n_pop++;
    end
    if (v && o_ready) begin
      exp_q.push_back(use_e ? e : model(b));
      accepted = 1'b1;
    end
  endtask

  task automatic drain();
    in_t  nb;
    res_t nr;
    nb = '0;
    nr = '0;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) cycle(1'b0, 1'b1, nb, 1'b0, nr);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_directed(input in_t b, input res_t e);
    in_t  nb;
    res_t nr;
    nb = '0;
    nr = '0;
    cycle(1'b1, 1'b1, b, 1'b1, e);
    check("directed_accept", 64'(accepted), 64'd1);
    drain();
  endtask

  in_t  nb0, bt;
  res_t nr0, er;
  in_t  beats[6];
  int   idx, lat;

  initial begin
    nb0 = '0;
    nr0 = '0;
    hold_chk = 1'b0;
    saw_not_ready = 1'b0;

    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_o_ready", 64'(o_ready), 64'd1);
    check("reset_outputs", 64'(dut_res), 64'd0);

    // Exact cancellation.
    bt = '{sa:1'b0, ea:8'h7F, fa:32'h8000_0000, sb:1'b1, eb:8'h7F, fb:32'h8000_0000, sc:1'b0, fl:1'b1};
    er = '{s:1'b0, e:8'h00, f:32'h0, sc:1'b0, fl:1'b1};
    send_directed(bt, er);
    // Equal operands add with carry-out.
    bt = '{sa:1'b0, ea:8'h7F, fa:32'h8000_0000, sb:1'b0, eb:8'h7F, fb:32'h8000_0000, sc:1'b1, fl:1'b1};
    er = '{s:1'b0, e:8'h80, f:32'h8000_0000, sc:1'b1, fl:1'b1};
    send_directed(bt, er);
    // Partial cancellation needing a left shift.
    bt = '{sa:1'b0, ea:8'h80, fa:32'h8000_0000, sb:1'b1, eb:8'h7F, fb:32'hC000_0000, sc:1'b0, fl:1'b0};
    er = '{s:1'b0, e:8'h7E, f:32'h8000_0000, sc:1'b0, fl:1'b0};
    send_directed(bt, er);
    // Bias shifted entirely out.
    bt = '{sa:1'b1, ea:8'h7F, fa:32'hFFFF_FFFF, sb:1'b0, eb:8'h40, fb:32'h8000_0000, sc:1'b1, fl:1'b0};
    er = '{s:1'b1, e:8'h7F, f:32'hFFFF_FFFF, sc:1'b1, fl:1'b0};
    send_directed(bt, er);
    // Carry at the maximum exponent saturates.
    bt = '{sa:1'b1, ea:8'hFF, fa:32'hC000_0000, sb:1'b1, eb:8'hFF, fb:32'h8000_0000, sc:1'b0, fl:1'b0};
    er = '{s:1'b1, e:8'hFF, f:32'hFFFF_FFFF, sc:1'b0, fl:1'b0};
    send_directed(bt, er);
    // Zero A with a large exponent leaves the bias unchanged.
    bt = '{sa:1'b0, ea:8'hF0, fa:32'h0, sb:1'b1, eb:8'h03, fb:32'h9000_0001, sc:1'b0, fl:1'b1};
    er = '{s:1'b1, e:8'h03, f:32'h9000_0001, sc:1'b0, fl:1'b1};
    send_directed(bt, er);
    // Leading-zero shift exceeding the exponent flushes to zero.
    bt = '{sa:1'b0, ea:8'h02, fa:32'h8000_0000, sb:1'b1, eb:8'h02, fb:32'h7000_0000, sc:1'b1, fl:1'b1};
    er = '{s:1'b0, e:8'h00, f:32'h0, sc:1'b1, fl:1'b1};
    send_directed(bt, er);

    // Six-beat stream with the consumer stalled on cycles 4-7.
    for (int k = 0; k < 6; k++) beats[k] = rand_in();
    idx = 0;
    saw_not_ready = 1'b0;
    n_pop = 0;
    for (int c = 0; c < 60 && (idx < 6 || exp_q.size() > 0); c++) begin
      cycle(idx < 6, !(c >= 4 && c <= 7), (idx < 6) ? beats[idx] : nb0, 1'b0, nr0);
      if (accepted) idx++;
    end
    check("stream_ready_drop", 64'(saw_not_ready), 64'd1);
    check("stream_out_count", 64'(n_pop), 64'd6);
    check("stream_in_count", 64'(idx), 64'd6);

    // Reset with three beats in flight behind a stalled consumer.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, rand_in(), 1'b0, nr0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    hold_chk = 1'b0;
    #1;
    check("midreset_o_valid", 64'(o_valid), 64'd0);
    check("midreset_o_ready", 64'(o_ready), 64'd1);
    cycle(1'b1, 1'b1, rand_in(), 1'b0, nr0);
    check("midreset_accept", 64'(accepted), 64'd1);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      cycle(1'b0, 1'b1, nb0, 1'b0, nr0);
      if (popped) lat = k;
    end
    check("midreset_latency", 64'(lat), 64'd3);
    drain();

    // Randomized traffic with random valid and back-pressure.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), rand_in(), 1'b0, nr0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/map_sub.md
Name: map_sub

Overview:
- Pipelined signed-magnitude floating adder directly downstream of the pre-map decode stage.
- Consumes operand A and the selected bias constant, both in split sign/exp/frac form, and forms the reduced argument A + BIAS (operand signs encode subtract direction).
- Result is normalized and handed to the polynomial/CORDIC core.
- Carries the sin/cos mode and result-sign-flip sideband in lockstep with the data.

Parameters:
- EXP_WIDTH, 8, exponent field width (unsigned, compared as magnitude).
- FRAC_WIDTH, 32, fraction width; MSB is the explicit integer bit. frac==0 means zero.
- GUARD, 2, extra low-order alignment bits kept internally; truncated at output.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous, active-high reset
- i_valid  input  1  input beat valid
- o_ready  output  1  stage can accept a beat
- i_sign_a  input  1  operand A sign
- i_exp_a  input  EXP_WIDTH  operand A exponent
- i_frac_a  input  FRAC_WIDTH  operand A fraction
- i_sign_bias  input  1  bias sign
- i_exp_bias  input  EXP_WIDTH  bias exponent
- i_frac_bias  input  FRAC_WIDTH  bias fraction
- i_sincos_proced  input  1  sideband: sin/cos mode
- i_RESULT_SIGN_FLIP  input  1  sideband: final sign flip
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_sign_r  output  1  result sign
- o_exp_r  output  EXP_WIDTH  result exponent
- o_frac_r  output  FRAC_WIDTH  normalized result fraction (MSB=1 unless zero)
- o_sincos_proced  output  1  delayed sideband
- o_RESULT_SIGN_FLIP  output  1  delayed sideband

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: all stage valid bits 0, o_valid=0, all data/sideband output registers 0. o_ready=1 in the cycle after reset deasserts.
- Pipeline: 3 register stages S1 align, S2 add, S3 normalize. Latency is 3 cycles from accepted input to o_valid with no stall. Throughput is 1 beat/cycle.
- Handshake:
  - Input transfer when i_valid & o_ready. Output transfer when o_valid & i_ready.
  - o_ready = ~o_valid | i_ready | (some earlier stage empty). Each stage advances when its successor is empty or advancing.
  - Bubbles collapse. No beat is dropped or duplicated. Data is held stable while o_valid & ~i_ready.
- S1 align:
  - Operand with larger {exp,frac} magnitude is BIG; ties pick A.
  - d = exp_big - exp_small. Small frac is extended by GUARD zero bits and shifted right by d.
  - If d >= FRAC_WIDTH+GUARD, small contributes 0.
  - Register sign_big, eff_sub = sign_a ^ sign_bias, exp_big, both aligned fracs, sideband.
- S2 add:
  - sum = big ± small in FRAC_WIDTH+GUARD+1 bits; subtract when eff_sub.
  - Result is never negative (BIG ≥ small). Sign = sign_big.
- S3 normalize:
  - Carry out: shift right 1, exp+1. If exp_big was all-ones, saturate: exp all-ones, frac all-ones.
  - Else LZC on sum: shift left by lz, exp - lz.
  - If lz > exp_big: flush to zero.
  - Output frac = top FRAC_WIDTH bits (truncate guard bits).
- Zero result (sum==0, exact cancellation, or flush): sign 0, exp 0, frac 0.
- Zero operands: frac==0 is treated as zero magnitude regardless of exp, so result = the other operand unchanged.
- Sideband: passed unmodified, aligned with its beat.
- Reset mid-operation: all in-flight beats are discarded, with no output of them after reset.

Test Plan:
- A=(0,0x7F,0x80000000), BIAS=(1,0x7F,0x80000000) -> after 3 cycles o_sign_r=0, o_exp_r=0x00, o_frac_r=0x00000000.
- A=(0,0x7F,0x80000000), BIAS=(0,0x7F,0x80000000) -> o_exp_r=0x80, o_frac_r=0x80000000, o_sign_r=0.
- A=(0,0x80,0x80000000), BIAS=(1,0x7F,0xC00000000>>4=0xC0000000) -> cancellation: o_exp_r=0x7E, o_frac_r=0x80000000, o_sign_r=0.
- A=(1,0x7F,0xFFFFFFFF), BIAS=(0,0x40,0x80000000) with d≥34 -> output equals A exactly; sideband {i_sincos_proced=1, i_RESULT_SIGN_FLIP=0} appears unchanged on the same beat.
- Stream 6 beats with i_ready low for cycles 4-7 -> o_ready drops once the pipeline is full; all 6 results emerge in order with no loss; data is stable during the stall.
- Assert i_rst for 1 cycle while 3 beats are in flight -> o_valid=0 next cycle, no stale result appears, and the next accepted beat emerges 3 cycles later.
